jtdsp16_sio: RTL and testbench

JTDSP16_SIO -- requirements
Module: jtdsp16_sio

---
 rtl/jtdsp16_pkg.sv | 25 ++
 rtl/jtdsp16_sio_rx.sv | 75 +++++++
 rtl/jtdsp16_sio.sv | 150 +++++++++++++++
 tb/tb_jtdsp16_sio.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the JTDSP16 serial I/O block: IOC bit map, output FSM
// states and serial word lengths.
package jtdsp16_pkg;

  localparam int IOC_W      = 5;
  localparam int IOC_OLEN   = 0;
  localparam int IOC_ILEN   = 1;
  localparam int IOC_MSB    = 2;
  localparam int IOC_DIV_LO = 3;
  localparam int IOC_DIV_HI = 4;

  localparam logic [4:0] LEN_8  = 5'd8;
  localparam logic [4:0] LEN_16 = 5'd16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } sio_state_t;

  function automatic logic [4:0] word_len(input logic short_word);
    return short_word ? LEN_8 : LEN_16;
  endfunction

endpackage

// File: rtl/jtdsp16_sio_rx.sv
// Serial input receiver: synchronises di/ick/ild, arms on an ild rise and
// assembles an 8- or 16-bit word (MSB received first) into dout.
module jtdsp16_sio_rx
  import jtdsp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        ilen,
  input  logic        di,
  input  logic        ick,
  input  logic        ild,
  input  logic        sdx_rd,
  output logic [15:0] dout,
  output logic        ibf
);

  logic [1:0]  di_s, ick_s, ild_s;
  logic        ick_q, ild_q;
  logic        ick_rise, ild_rise;
  logic        armed, short_word, done;
  logic [4:0]  cnt;
  logic [15:0] sr, word;

  always_ff @(posedge clk) begin
    if (rst) begin
      di_s  <= '0;
      ick_s <= '0;
      ild_s <= '0;
    end else begin
      di_s  <= {di_s[0], di};
      ick_s <= {ick_s[0], ick};
      ild_s <= {ild_s[0], ild};
    end
  end

  assign ick_rise = ick_s[1] & ~ick_q;
  assign ild_rise = ild_s[1] & ~ild_q;
  assign done     = armed && ick_rise && !ild_rise && ((cnt + 5'd1) == word_len(short_word));
  assign word     = short_word ? {8'h00, sr[6:0], di_s[1]} : {sr[14:0], di_s[1]};

  // A completing word beats a simultaneous read, so ibf never drops on that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ick_q      <= 1'b0;
      ild_q      <= 1'b0;
      armed      <= 1'b0;
      short_word <= 1'b0;
      cnt        <= '0;
      sr         <= '0;
      dout       <= '0;
      ibf        <= 1'b0;
    end else if (cen) begin
      ick_q <= ick_s[1];
      ild_q <= ild_s[1];
      if (ild_rise) begin
        armed      <= 1'b1;
        cnt        <= '0;
        sr         <= '0;
        short_word <= ilen;
      end else if (armed && ick_rise) begin
        sr  <= {sr[14:0], di_s[1]};
        cnt <= cnt + 5'd1;
        if (done) armed <= 1'b0;
      end
      if (done) begin
        dout <= word;
        ibf  <= 1'b1;
      end else if (sdx_rd) begin
        ibf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jtdsp16_sio.sv
// JTDSP16 serial I/O port: IOC register, serial clock divider and output FSM.
// Define JTDSP16_SIO_INPUT_EN to include the serial input receiver.
module jtdsp16_sio
  import jtdsp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        sdx_wr,
  input  logic        sdx_rd,
  input  logic        ioc_wr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        sdo,
  output logic        ock,
  output logic        old,
  output logic        doen,
  output logic        ose,
  input  logic        di,
  input  logic        ick,
  input  logic        ild,
  output logic        ibf,
  output logic        siord_full,
  output logic        siowr_empty
);

  logic [IOC_W-1:0] ioc;
  logic [3:0]       div_cnt;
  logic [4:0]       half_m1;
  logic             ock_tick, ock_fall;
  sio_state_t       state;
  logic [15:0]      hold_data, shreg, load_word, shifted;
  logic             hold_full, cur_msb, out_bit;
  logic [4:0]       cur_len, bit_cnt;

  always_ff @(posedge clk) begin
    if (rst)               ioc <= '0;
    else if (cen && ioc_wr) ioc <= din[IOC_W-1:0];
  end

  // Half period of ock is 2^(clkdiv+1) cen ticks.
  assign half_m1  = (5'd2 << ioc[IOC_DIV_HI:IOC_DIV_LO]) - 5'd1;
  assign ock_tick = cen && ({1'b0, div_cnt} >= half_m1);
  assign ock_fall = ock_tick && ock;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      ock     <= 1'b0;
    end else if (cen) begin
      if (ock_tick) begin
        div_cnt <= '0;
        ock     <= ~ock;
      end else begin
        div_cnt <= div_cnt + 4'd1;
      end
    end
  end

  // 8-bit MSB-first words are pre-aligned so the shift direction alone picks the bit.
  assign load_word = (ioc[IOC_OLEN] && ioc[IOC_MSB]) ? {hold_data[7:0], 8'h00} : hold_data;
  assign out_bit   = cur_msb ? shreg[15] : shreg[0];
  assign shifted   = cur_msb ? {shreg[14:0], 1'b0} : {1'b0, shreg[15:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_data <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      cur_msb   <= 1'b0;
      cur_len   <= LEN_16;
      bit_cnt   <= '0;
      sdo       <= 1'b0;
      old       <= 1'b0;
      doen      <= 1'b0;
      ose       <= 1'b1;
    end else if (cen) begin
      if (ock_fall) begin
        case (state)
          IDLE: if (hold_full) begin
            state     <= LOAD;
            old       <= 1'b1;
            hold_full <= 1'b0;
            shreg     <= load_word;
            cur_msb   <= ioc[IOC_MSB];
            cur_len   <= word_len(ioc[IOC_OLEN]);
          end
          LOAD: begin
            state   <= SHIFT;
            old     <= 1'b0;
            doen    <= 1'b1;
            sdo     <= out_bit;
            shreg   <= shifted;
            bit_cnt <= 5'd1;
          end
          SHIFT: if (bit_cnt == cur_len) begin
            doen <= 1'b0;
            sdo  <= 1'b0;
            if (hold_full) begin
              state     <= LOAD;
              old       <= 1'b1;
              hold_full <= 1'b0;
              shreg     <= load_word;
              cur_msb   <= ioc[IOC_MSB];
              cur_len   <= word_len(ioc[IOC_OLEN]);
            end else begin
              state <= IDLE;
              ose   <= 1'b1;
            end
          end else begin
            sdo     <= out_bit;
            shreg   <= shifted;
            bit_cnt <= bit_cnt + 5'd1;
          end
          default: state <= IDLE;
        endcase
      end
      if (sdx_wr) begin
        hold_data <= din;
        hold_full <= 1'b1;
        ose       <= 1'b0;
      end
    end
  end

`ifdef JTDSP16_SIO_INPUT_EN
  jtdsp16_sio_rx u_rx (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .ilen   (ioc[IOC_ILEN]),
    .di     (di),
    .ick    (ick),
    .ild    (ild),
    .sdx_rd (sdx_rd),
    .dout   (dout),
    .ibf    (ibf)
  );
`else
  logic unused_rx;
  assign unused_rx = &{1'b0, di, ick, ild, sdx_rd, ioc[IOC_ILEN]};
  assign dout      = '0;
  assign ibf       = 1'b0;
`endif

  assign siord_full  = ibf;
  assign siowr_empty = ose;

endmodule

// File: tb/tb_jtdsp16_sio.sv
// Scoreboard bench for jtdsp16_sio: expected serial bits and received words are
// queued by the stimulus and popped by a monitor when the DUT presents them.
module tb_jtdsp16_sio;

  logic        clk = 1'b0;
  logic        rst, cen, sdx_wr, sdx_rd, ioc_wr;
  logic [15:0] din, dout;
  logic        sdo, ock, old, doen, ose;
  logic        di, ick, ild;
  logic        ibf, siord_full, siowr_empty;

  localparam logic [2:0] WR  = 3'b001;
  localparam logic [2:0] RD  = 3'b010;
  localparam logic [2:0] IOC = 3'b100;

  int          n_vec = 0;
  int          n_err = 0;
  logic        exp_bits[$];
  logic [15:0] exp_dout[$];
  int          bits_seen = 0, old_pulses = 0, doen_cycles = 0, ock_moves = 0;
  logic        ock_prev = 1'b0, old_prev = 1'b0, ibf_prev = 1'b0, pause = 1'b0;

  always #5 clk = ~clk;

  jtdsp16_sio dut (
    .clk(clk), .rst(rst), .cen(cen),
    .sdx_wr(sdx_wr), .sdx_rd(sdx_rd), .ioc_wr(ioc_wr),
    .din(din), .dout(dout),
    .sdo(sdo), .ock(ock), .old(old), .doen(doen), .ose(ose),
    .di(di), .ick(ick), .ild(ild),
    .ibf(ibf), .siord_full(siord_full), .siowr_empty(siowr_empty)
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] strobe, input logic [15:0] data);
    din = data;
    {ioc_wr, sdx_rd, sdx_wr} = strobe;
    @(negedge clk);
    {ioc_wr, sdx_rd, sdx_wr} = 3'b000;
  endtask

  task automatic pushWord(input logic [15:0] w, input bit short_word, input bit msb_first);
    int n = short_word ? 8 : 16;
    for (int i = 0; i < n; i++)
      exp_bits.push_back(msb_first ? w[n-1-i] : w[i]);
  endtask

  function automatic bit cond(input int which, input int arg);
    case (which)
      0:       return ose === 1'b1;
      1:       return doen === 1'b1;
      2:       return ibf === 1'b1;
      3:       return doen === 1'b0;
      default: return bits_seen >= arg;
    endcase
  endfunction

  task automatic waitUntil(input string name, input int which, input int arg, input int limit);
    int k = 0;
    while (!cond(which, arg) && k < limit) begin
      @(negedge clk);
      k++;
    end
    checkOutput({"wait ", name}, 16'(cond(which, arg)), 16'd1);
  endtask

  task automatic sendSerial(input logic [15:0] w, input int n, input bit coincide);
    ild = 1'b1; repeat (4) @(negedge clk);
    ild = 1'b0; repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      di = w[n-1-i];
      repeat (2) @(negedge clk);
      ick = 1'b1;
      if (coincide && i == n - 1) begin
        // Two sync stages then the edge detector: the word completes on the third posedge.
        repeat (2) @(negedge clk);
        sdx_rd = 1'b1;
        @(negedge clk);
        sdx_rd = 1'b0;
        repeat (2) @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      ick = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  // Monitor: a serial bit is presented on every ock fall while doen is high.
  always @(negedge clk) begin
    if (ock_prev && !ock && doen) begin
      bits_seen++;
      if (exp_bits.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected serial bit: got %0b, expected none", sdo);
      end else begin
        checkOutput("sdo bit", {15'd0, sdo}, {15'd0, exp_bits.pop_front()});
      end
    end
    if (doen) doen_cycles++;
    if (old && !old_prev) old_pulses++;
    if (pause && ock !== ock_prev) ock_moves++;
    if (ibf && !ibf_prev) begin
      if (exp_dout.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected ibf rise: got dout 0x%04h, expected none", dout);
      end else begin
        checkOutput("dout on ibf", dout, exp_dout.pop_front());
      end
    end
    ock_prev = ock;
    old_prev = old;
    ibf_prev = ibf;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int old0, b0;
    rst = 1'b1; cen = 1'b1; sdx_wr = 1'b0; sdx_rd = 1'b0; ioc_wr = 1'b0;
    din = '0; di = 1'b0; ick = 1'b0; ild = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset sdo", {15'd0, sdo}, 16'd0);
    checkOutput("reset ock", {15'd0, ock}, 16'd0);
    checkOutput("reset old", {15'd0, old}, 16'd0);
    checkOutput("reset doen", {15'd0, doen}, 16'd0);
    checkOutput("reset ose", {15'd0, ose}, 16'd1);
    checkOutput("reset siowr_empty", {15'd0, siowr_empty}, 16'd1);
    checkOutput("reset ibf", {15'd0, ibf}, 16'd0);
    checkOutput("reset siord_full", {15'd0, siord_full}, 16'd0);
    checkOutput("reset dout", dout, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] 16-bit MSB-first 0xA5C3");
    applyStimulus(IOC, 16'h0004);
    pushWord(16'hA5C3, 1'b0, 1'b1);
    old0 = old_pulses;
    applyStimulus(WR, 16'hA5C3);
    checkOutput("ose after write", {15'd0, ose}, 16'd0);
    checkOutput("siowr_empty after write", {15'd0, siowr_empty}, 16'd0);
    waitUntil("ose A5C3", 0, 0, 400);
    checkOutput("bits left A5C3", 16'(exp_bits.size()), 16'd0);
    checkOutput("old pulses A5C3", 16'(old_pulses - old0), 16'd1);
    checkOutput("doen idle A5C3", {15'd0, doen}, 16'd0);

    $display("[TB] 8-bit LSB-first 0x12F0");
    applyStimulus(IOC, 16'h0001);
    pushWord(16'h12F0, 1'b1, 1'b0);
    doen_cycles = 0;
    applyStimulus(WR, 16'h12F0);
    waitUntil("ose 12F0", 0, 0, 400);
    checkOutput("doen cycles 8-bit", 16'(doen_cycles), 16'd32);
    checkOutput("bits left 12F0", 16'(exp_bits.size()), 16'd0);

    $display("[TB] overwrite during shift, IOC change for next word");
    applyStimulus(IOC, 16'h0004);
    pushWord(16'h1111, 1'b0, 1'b1);
    pushWord(16'h3333, 1'b1, 1'b0);
    old0 = old_pulses;
    b0   = bits_seen;
    applyStimulus(WR, 16'h1111);
    waitUntil("doen 1111", 1, 0, 100);
    applyStimulus(WR, 16'h2222);
    repeat (3) @(negedge clk);
    applyStimulus(IOC, 16'h0001);
    applyStimulus(WR, 16'h3333);
    waitUntil("16 bits 1111", 4, b0 + 16, 400);
    waitUntil("doen low after 1111", 3, 0, 20);
    checkOutput("ose between words", {15'd0, ose}, 16'd0);
    waitUntil("ose 3333", 0, 0, 400);
    checkOutput("bits left 3333", 16'(exp_bits.size()), 16'd0);
    checkOutput("old pulses back-to-back", 16'(old_pulses - old0), 16'd2);

    $display("[TB] clkdiv 1, 8-bit MSB-first 0x00A5");
    applyStimulus(IOC, 16'h000D);
    pushWord(16'h00A5, 1'b1, 1'b1);
    doen_cycles = 0;
    applyStimulus(WR, 16'h00A5);
    waitUntil("ose 00A5", 0, 0, 600);
    checkOutput("doen cycles div1", 16'(doen_cycles), 16'd64);
    checkOutput("bits left 00A5", 16'(exp_bits.size()), 16'd0);

    $display("[TB] cen held low");
    ock_moves = 0;
    cen = 1'b0;
    @(negedge clk);
    pause = 1'b1;
    repeat (20) @(negedge clk);
    pause = 1'b0;
    cen = 1'b1;
    checkOutput("ock frozen without cen", 16'(ock_moves), 16'd0);

    $display("[TB] reset mid-transfer");
    applyStimulus(IOC, 16'h0004);
    pushWord(16'hFFFF, 1'b0, 1'b1);
    b0 = bits_seen;
    applyStimulus(WR, 16'hFFFF);
    waitUntil("5 bits FFFF", 4, b0 + 5, 200);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort sdo", {15'd0, sdo}, 16'd0);
    checkOutput("abort ose", {15'd0, ose}, 16'd1);
    checkOutput("abort doen", {15'd0, doen}, 16'd0);
    rst = 1'b0;
    exp_bits.delete();
    old0 = old_pulses;
    b0   = bits_seen;
    repeat (120) @(negedge clk);
    checkOutput("old after abort", 16'(old_pulses - old0), 16'd0);
    checkOutput("bits after abort", 16'(bits_seen - b0), 16'd0);

`ifdef JTDSP16_SIO_INPUT_EN
    $display("[TB] serial input 16-bit 0xBEEF");
    exp_dout.push_back(16'hBEEF);
    sendSerial(16'hBEEF, 16, 1'b0);
    waitUntil("ibf BEEF", 2, 0, 20);
    checkOutput("dout BEEF", dout, 16'hBEEF);
    checkOutput("siord_full BEEF", {15'd0, siord_full}, 16'd1);
    applyStimulus(RD, 16'h0000);
    checkOutput("ibf after read", {15'd0, ibf}, 16'd0);
    checkOutput("siord_full after read", {15'd0, siord_full}, 16'd0);
    exp_dout.push_back(16'h1234);
    sendSerial(16'h1234, 16, 1'b0);
    waitUntil("ibf 1234", 2, 0, 20);
    applyStimulus(IOC, 16'h0002);
    sendSerial(16'h00C3, 8, 1'b1);
    checkOutput("ibf completion beats read", {15'd0, ibf}, 16'd1);
    checkOutput("dout 8-bit overwrite", dout, 16'h00C3);
    checkOutput("rx words left", 16'(exp_dout.size()), 16'd0);
`else
    $display("[TB] serial input ignored in this build");
    sendSerial(16'hBEEF, 16, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("ibf without input", {15'd0, ibf}, 16'd0);
    checkOutput("siord_full without input", {15'd0, siord_full}, 16'd0);
    checkOutput("dout without input", dout, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
